// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/exception vectors,
// CP0 STATUS/CAUSE bit positions, next-PC source selector and the interrupt
// pending helper.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'hbfc00380;

    // CP0 STATUS fields
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_HI   = 15;
    localparam int STATUS_IM_LO   = 8;

    // CP0 CAUSE fields
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 8;

    // Source of the next fetch address, listed in priority order
    typedef enum logic [2:0] {
        SEL_EXC   = 3'd0,
        SEL_ERET  = 3'd1,
        SEL_STALL = 3'd2,
        SEL_J     = 3'd3,
        SEL_JR    = 3'd4,
        SEL_BR    = 3'd5,
        SEL_SEQ   = 3'd6
    } pc_sel_e;

    // An interrupt is pending when enabled, not already in exception level,
    // and at least one unmasked line is asserted.
    function automatic logic int_pending(input logic [31:0] status,
                                         input logic [31:0] cause);
        logic [7:0] im;
        logic [7:0] ip;
        im = status[STATUS_IM_HI:STATUS_IM_LO];
        ip = cause[CAUSE_IP_HI:CAUSE_IP_LO];
        return status[STATUS_IE_BIT] & ~status[STATUS_EXL_BIT] & (|(ip & im));
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next fetch address selection: a pure combinational priority mux over
// exception, eret, stall, jump, jump-register, taken branch and sequential.
module if_next_pc
    import if_stage_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic        exc_valid,
    input  logic        eret,
    input  logic        stall,
    input  logic        j_type,
    input  logic        jr_type,
    input  logic        br_type,
    input  logic        br_taken,
    input  logic [15:0] br_index,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_index,
    input  logic [31:0] epc,
    input  logic [31:0] pc_q,
    output logic [31:0] next_pc
);

    pc_sel_e            sel;
    logic signed [31:0] br_off;

    // Branch offset is the sign-extended word offset; base is the delay-slot PC.
    assign br_off = {{14{br_index[15]}}, br_index, 2'b00};

    // Resolve which redirect source wins this cycle
    always_comb begin
        sel = SEL_SEQ;
        if (exc_valid)                sel = SEL_EXC;
        else if (eret)                sel = SEL_ERET;
        else if (stall)               sel = SEL_STALL;
        else if (j_type)              sel = SEL_J;
        else if (jr_type)             sel = SEL_JR;
        else if (br_type && br_taken) sel = SEL_BR;
    end

    // Form the address for the selected source
    always_comb begin
        next_pc = pc_q + 32'd4;
        case (sel)
            SEL_EXC:   next_pc = EXC_VEC;
            SEL_ERET:  next_pc = epc;
            SEL_STALL: next_pc = pc_q;
            SEL_J:     next_pc = {pc_q[31:28], j_index, 2'b00};
            SEL_JR:    next_pc = jr_index;
            SEL_BR:    next_pc = pc_q + $unsigned(br_off);
            default:   next_pc = pc_q + 32'd4;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// SRAM and presents the fetched word plus BD/address-error/interrupt tags to
// decode. A bubble is presented as inst 0 at RESET_PC.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ID_stall,
    input  logic        ID_br_taken,
    input  logic        ID_br_type,
    input  logic        ID_j_type,
    input  logic        ID_jr_type,
    input  logic [15:0] ID_br_index,
    input  logic [25:0] ID_j_index,
    input  logic [31:0] ID_jr_index,
    input  logic        ID_delay_slot,
    input  logic        ID_eret,
    input  logic        exc_valid,
    input  logic [31:0] CP0_EPC,
    input  logic [31:0] CP0_STATUS,
    input  logic [31:0] CP0_CAUSE,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic        IF_BD,
    output logic        IF_inst_addr_err,
    output logic        IF_interrupt
);

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        if_valid;
    logic        int_sent;
    logic        int_pend;
    logic        misaligned;
    logic        unused_cp0;

    // Only the IE/EXL/IM and IP fields of CP0 are consumed here
    assign unused_cp0 = ^{CP0_STATUS[31:16], CP0_STATUS[7:2],
                          CP0_CAUSE[31:16], CP0_CAUSE[7:0]};

    if_next_pc #(
        .EXC_VEC (EXC_VEC)
    ) u_next_pc (
        .exc_valid (exc_valid),
        .eret      (ID_eret),
        .stall     (ID_stall),
        .j_type    (ID_j_type),
        .jr_type   (ID_jr_type),
        .br_type   (ID_br_type),
        .br_taken  (ID_br_taken),
        .br_index  (ID_br_index),
        .j_index   (ID_j_index),
        .jr_index  (ID_jr_index),
        .epc       (CP0_EPC),
        .pc_q      (pc_q),
        .next_pc   (next_pc)
    );

    // The SRAM is addressed with next_pc so its data lines up with pc_q next
    // cycle; a stall re-issues pc_q so the held word stays coherent.
    assign inst_sram_addr = next_pc;
    assign inst_sram_en   = resetn & (next_pc[1:0] == 2'b00);

    // PC register; if_valid marks that rdata belongs to pc_q (0 right after reset)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= RESET_PC - 32'd4;
            if_valid <= 1'b0;
        end else begin
            pc_q     <= next_pc;
            if_valid <= 1'b1;
        end
    end

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign int_pend   = int_pending(CP0_STATUS, CP0_CAUSE);

    // Outputs to decode; misaligned fetches carry a zero word and the bad PC
    assign IF_pc            = if_valid ? pc_q : RESET_PC;
    assign IF_inst          = (if_valid && !misaligned) ? inst_sram_rdata : 32'd0;
    assign IF_BD            = ID_delay_slot & if_valid;
    assign IF_inst_addr_err = misaligned & if_valid;
    assign IF_interrupt     = int_pend & ~int_sent & if_valid & ~ID_eret & ~exc_valid;

    // Remember that the current interrupt event has been tagged onto an
    // accepted instruction, so it is tagged only once until serviced.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            int_sent <= 1'b0;
        end else if (exc_valid || !int_pend) begin
            int_sent <= 1'b0;
        end else if (IF_interrupt && !ID_stall) begin
            int_sent <= 1'b1;
        end
    end

endmodule
